// File: rtl/vend_change_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | vend_change_controller : coin credit accumulator, auto-vend and change return
// | rev 1.0
// +-----------------------------------------------------------------------------
module vend_change_controller #(
  parameter int PRICE      = 25,
  parameter int MAX_CREDIT = 60,
  parameter int CREDIT_W   = 6
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic                Cancel,
  input  logic                RetAck,
  output logic                Candy,
  output logic [CREDIT_W-1:0] Number,
  output logic                RetValid,
  output logic [1:0]          RetCoin,
  output logic                CoinReject,
  output logic                Busy
);

  localparam int                  SUM_W     = CREDIT_W + 1;
  localparam logic [SUM_W-1:0]    PRICE_X   = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0]    MAX_X     = SUM_W'(MAX_CREDIT);
  localparam logic [SUM_W-1:0]    NICKEL_X  = SUM_W'(5);
  localparam logic [SUM_W-1:0]    DIME_X    = SUM_W'(10);
  localparam logic [SUM_W-1:0]    QUARTER_X = SUM_W'(25);
  localparam logic [CREDIT_W-1:0] PRICE_N   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL_N  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] DIME_N    = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] QUARTER_N = CREDIT_W'(25);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] VEND   = 2'd1;
  localparam logic [1:0] CHANGE = 2'd2;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [CREDIT_W-1:0] number_next;

  logic                n_q;
  logic                d_q;
  logic                q_q;
  logic                armed;
  logic                n_edge;
  logic                d_edge;
  logic                q_edge;
  logic                any_edge;

  logic [SUM_W-1:0]    credit_x;
  logic [SUM_W-1:0]    coin_sum;
  logic [SUM_W-1:0]    total;
  logic                vend_now;
  logic                accept;
  logic [1:0]          ret_code;
  logic [CREDIT_W-1:0] ret_value;
  logic [CREDIT_W-1:0] remain;

  // 'armed' masks the first cycle after reset so a line already high at
  // reset release is treated as history, not as a fresh coin.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      n_q   <= 1'b0;
      d_q   <= 1'b0;
      q_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      n_q   <= N;
      d_q   <= D;
      q_q   <= Q;
      armed <= 1'b1;
    end
  end

  assign n_edge   = armed & N & ~n_q;
  assign d_edge   = armed & D & ~d_q;
  assign q_edge   = armed & Q & ~q_q;
  assign any_edge = n_edge | d_edge | q_edge;

  always_comb begin
    coin_sum = '0;
    if (n_edge) coin_sum = coin_sum + NICKEL_X;
    if (d_edge) coin_sum = coin_sum + DIME_X;
    if (q_edge) coin_sum = coin_sum + QUARTER_X;
  end

  assign credit_x = {1'b0, Number};
  assign total    = credit_x + coin_sum;
  assign vend_now = (credit_x >= PRICE_X);
  assign accept   = (state == IDLE) && !vend_now && any_edge && (total <= MAX_X);

  // Greedy change selection; credit is always a multiple of 5 here.
  always_comb begin
    ret_code  = COIN_NICKEL;
    ret_value = NICKEL_N;
    if (credit_x >= QUARTER_X) begin
      ret_code  = COIN_QUARTER;
      ret_value = QUARTER_N;
    end else if (credit_x >= DIME_X) begin
      ret_code  = COIN_DIME;
      ret_value = DIME_N;
    end
  end

  assign remain = Number - ret_value;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      Number <= '0;
    end else begin
      state  <= state_next;
      Number <= number_next;
    end
  end

  always_comb begin
    state_next  = state;
    number_next = Number;
    case (state)
      IDLE: begin
        if (vend_now) begin
          state_next  = VEND;
          number_next = Number - PRICE_N;
        end else begin
          if (accept) number_next = total[CREDIT_W-1:0];
          // A cancel that coincides with coins refunds the new total, unless
          // those coins pushed credit to the price, in which case vend wins.
          if (Cancel && (accept ? (total < PRICE_X) : (Number != '0)))
            state_next = CHANGE;
        end
      end
      VEND: begin
        state_next = (Number != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (RetAck) begin
          number_next = remain;
          if (remain == '0) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    Candy      = (state == VEND);
    Busy       = (state == VEND) || (state == CHANGE);
    RetValid   = (state == CHANGE);
    RetCoin    = (state == CHANGE) ? ret_code : COIN_NONE;
    CoinReject = any_edge && !accept;
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_change_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_vend_change_controller : directed self-checking bench
// | rev 1.0
// +-----------------------------------------------------------------------------
module tb_vend_change_controller;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       N = 1'b0, D = 1'b0, Q = 1'b0, Cancel = 1'b0, RetAck = 1'b0;
  logic       Candy, RetValid, CoinReject, Busy;
  logic [5:0] Number;
  logic [1:0] RetCoin;

  // Second build with PRICE=45 for the over-limit case
  logic       n2 = 1'b0, d2 = 1'b0, q2 = 1'b0, cancel2 = 1'b0, retack2 = 1'b1;
  logic       candy2, retvalid2, coinreject2, busy2;
  logic [5:0] number2;
  logic [1:0] retcoin2;

  int vectors    = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  vend_change_controller #(.PRICE(25), .MAX_CREDIT(60), .CREDIT_W(6)) dut (
    .Clk(Clk), .Rst(Rst), .N(N), .D(D), .Q(Q), .Cancel(Cancel), .RetAck(RetAck),
    .Candy(Candy), .Number(Number), .RetValid(RetValid), .RetCoin(RetCoin),
    .CoinReject(CoinReject), .Busy(Busy)
  );

  vend_change_controller #(.PRICE(45), .MAX_CREDIT(60), .CREDIT_W(6)) dut45 (
    .Clk(Clk), .Rst(Rst), .N(n2), .D(d2), .Q(q2), .Cancel(cancel2), .RetAck(retack2),
    .Candy(candy2), .Number(number2), .RetValid(retvalid2), .RetCoin(retcoin2),
    .CoinReject(coinreject2), .Busy(busy2)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1; N = 0; D = 0; Q = 0; Cancel = 0; RetAck = 0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1; Q = 1'b1;
    #3;
    vectors++;
    if ({Candy, RetValid, RetCoin, CoinReject, Busy, Number} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 0", {Candy, RetValid, RetCoin, CoinReject, Busy, Number});
    end
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    tick(); tick();
    vectors++;
    if (Number !== 6'd0) begin
      miscompares++; $display("FAIL held_q_through_reset: got %0d want 0", Number);
    end
    Q = 1'b0;
    tick();
    N = 1'b1;
    #1;
    vectors++;
    if (CoinReject !== 1'b0) begin
      miscompares++; $display("FAIL n_pulse_reject: got %b want 0", CoinReject);
    end
    tick();
    N = 1'b0;
    vectors++;
    if ({Number, Candy, Busy} !== {6'd5, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL n_pulse_credit: got num=%0d candy=%b busy=%b want 5/0/0", Number, Candy, Busy);
    end
  endtask

  task automatic test_hold_q();
    do_reset();
    Q = 1'b1;
    tick();
    vectors++;
    if ({Number, Candy} !== {6'd25, 1'b0}) begin
      miscompares++; $display("FAIL hold_q_credit: got num=%0d candy=%b want 25/0", Number, Candy);
    end
    tick();
    vectors++;
    if ({Number, Candy, Busy, RetValid, CoinReject} !== {6'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL hold_q_vend: got num=%0d candy=%b busy=%b rv=%b rej=%b want 0/1/1/0/0",
                              Number, Candy, Busy, RetValid, CoinReject);
    end
    tick();
    Q = 1'b0;
    vectors++;
    if ({Number, Candy, Busy, RetValid} !== {6'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL hold_q_idle: got num=%0d candy=%b busy=%b rv=%b want 0/0/0/0",
                              Number, Candy, Busy, RetValid);
    end
  endtask

  task automatic test_change_ack();
    do_reset();
    N = 1'b1;
    tick();
    vectors++;
    if (Number !== 6'd5) begin
      miscompares++; $display("FAIL dq_first_n: got %0d want 5", Number);
    end
    N = 1'b0; D = 1'b1; Q = 1'b1;
    tick();
    D = 1'b0; Q = 1'b0;
    vectors++;
    if (Number !== 6'd40) begin
      miscompares++; $display("FAIL dq_sum: got %0d want 40", Number);
    end
    tick();
    vectors++;
    if ({Candy, Number} !== {1'b1, 6'd15}) begin
      miscompares++; $display("FAIL dq_vend: got candy=%b num=%0d want 1/15", Candy, Number);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({RetValid, RetCoin, Number, Candy} !== {1'b1, 2'b10, 6'd15, 1'b0}) begin
        miscompares++; $display("FAIL hold_no_ack[%0d]: got rv=%b coin=%b num=%0d candy=%b want 1/10/15/0",
                                i, RetValid, RetCoin, Number, Candy);
      end
    end
    RetAck = 1'b1;
    tick();
    vectors++;
    if ({RetValid, RetCoin, Number} !== {1'b1, 2'b01, 6'd5}) begin
      miscompares++; $display("FAIL ack_dime: got rv=%b coin=%b num=%0d want 1/01/5", RetValid, RetCoin, Number);
    end
    tick();
    RetAck = 1'b0;
    vectors++;
    if ({RetValid, RetCoin, Number, Busy} !== {1'b0, 2'b00, 6'd0, 1'b0}) begin
      miscompares++; $display("FAIL ack_nickel: got rv=%b coin=%b num=%0d busy=%b want 0/00/0/0",
                              RetValid, RetCoin, Number, Busy);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    Cancel = 1'b1;
    tick();
    Cancel = 1'b0;
    vectors++;
    if ({Busy, RetValid} !== 2'b00) begin
      miscompares++; $display("FAIL cancel_zero: got busy=%b rv=%b want 0/0", Busy, RetValid);
    end
    N = 1'b1; tick();
    N = 1'b0; D = 1'b1; tick();
    D = 1'b0; Cancel = 1'b1; tick();
    Cancel = 1'b0;
    vectors++;
    if ({RetValid, RetCoin, Number, Candy} !== {1'b1, 2'b10, 6'd15, 1'b0}) begin
      miscompares++; $display("FAIL cancel_start: got rv=%b coin=%b num=%0d candy=%b want 1/10/15/0",
                              RetValid, RetCoin, Number, Candy);
    end
    RetAck = 1'b1;
    tick();
    vectors++;
    if ({RetCoin, Number, Candy} !== {2'b01, 6'd5, 1'b0}) begin
      miscompares++; $display("FAIL cancel_dime: got coin=%b num=%0d candy=%b want 01/5/0", RetCoin, Number, Candy);
    end
    tick();
    RetAck = 1'b0;
    vectors++;
    if ({RetValid, Number, Candy} !== {1'b0, 6'd0, 1'b0}) begin
      miscompares++; $display("FAIL cancel_done: got rv=%b num=%0d candy=%b want 0/0/0", RetValid, Number, Candy);
    end
  endtask

  task automatic test_vend_change20();
    do_reset();
    N = 1'b1; tick();
    N = 1'b0; D = 1'b1; tick();
    D = 1'b0; N = 1'b1; tick();
    N = 1'b0; Q = 1'b1; tick();
    Q = 1'b0;
    vectors++;
    if (Number !== 6'd45) begin
      miscompares++; $display("FAIL credit45: got %0d want 45", Number);
    end
    N = 1'b1;
    #1;
    vectors++;
    if (CoinReject !== 1'b1) begin
      miscompares++; $display("FAIL vend_cycle_reject: got %b want 1", CoinReject);
    end
    tick();
    N = 1'b0;
    vectors++;
    if ({Candy, Number} !== {1'b1, 6'd20}) begin
      miscompares++; $display("FAIL vend45: got candy=%b num=%0d want 1/20", Candy, Number);
    end
    tick();
    vectors++;
    if ({RetValid, RetCoin} !== {1'b1, 2'b10}) begin
      miscompares++; $display("FAIL change20_first: got rv=%b coin=%b want 1/10", RetValid, RetCoin);
    end
    RetAck = 1'b1;
    tick();
    vectors++;
    if ({RetCoin, Number} !== {2'b10, 6'd10}) begin
      miscompares++; $display("FAIL change20_second: got coin=%b num=%0d want 10/10", RetCoin, Number);
    end
    tick();
    RetAck = 1'b0;
    vectors++;
    if ({RetValid, Number} !== {1'b0, 6'd0}) begin
      miscompares++; $display("FAIL change20_done: got rv=%b num=%0d want 0/0", RetValid, Number);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    q2 = 1'b1; tick();
    q2 = 1'b0; d2 = 1'b1; tick();
    d2 = 1'b0; n2 = 1'b1; tick();
    n2 = 1'b0;
    vectors++;
    if ({number2, busy2} !== {6'd40, 1'b0}) begin
      miscompares++; $display("FAIL p45_credit40: got num=%0d busy=%b want 40/0", number2, busy2);
    end
    q2 = 1'b1;
    #1;
    vectors++;
    if (coinreject2 !== 1'b1) begin
      miscompares++; $display("FAIL p45_over_reject: got %b want 1", coinreject2);
    end
    tick();
    q2 = 1'b0;
    vectors++;
    if ({number2, candy2, coinreject2} !== {6'd40, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL p45_over_hold: got num=%0d candy=%b rej=%b want 40/0/0",
                              number2, candy2, coinreject2);
    end
    d2 = 1'b1; n2 = 1'b1; tick();
    d2 = 1'b0; n2 = 1'b0;
    vectors++;
    if (number2 !== 6'd55) begin
      miscompares++; $display("FAIL p45_credit55: got %0d want 55", number2);
    end
  endtask

  task automatic test_change_reject_reset();
    do_reset();
    D = 1'b1; tick();
    D = 1'b0; Q = 1'b1; tick();
    Q = 1'b0; tick();
    tick();
    vectors++;
    if ({RetValid, RetCoin, Number} !== {1'b1, 2'b10, 6'd10}) begin
      miscompares++; $display("FAIL cr_change: got rv=%b coin=%b num=%0d want 1/10/10", RetValid, RetCoin, Number);
    end
    N = 1'b1; Cancel = 1'b1;
    #1;
    vectors++;
    if (CoinReject !== 1'b1) begin
      miscompares++; $display("FAIL cr_reject: got %b want 1", CoinReject);
    end
    tick();
    N = 1'b0; Cancel = 1'b0;
    vectors++;
    if ({Number, RetValid, RetCoin} !== {6'd10, 1'b1, 2'b10}) begin
      miscompares++; $display("FAIL cr_unchanged: got num=%0d rv=%b coin=%b want 10/1/10", Number, RetValid, RetCoin);
    end
    #2 Rst = 1'b1;
    #1;
    vectors++;
    if ({RetValid, RetCoin, Number, Busy} !== {1'b0, 2'b00, 6'd0, 1'b0}) begin
      miscompares++; $display("FAIL async_reset: got rv=%b coin=%b num=%0d busy=%b want 0/00/0/0",
                              RetValid, RetCoin, Number, Busy);
    end
    tick();
    Rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_hold_q();
    test_change_ack();
    test_cancel();
    test_vend_change20();
    test_overflow();
    test_change_reject_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
